// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg                                                          |
// | Shared defaults, address-width helper and word typedefs.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_WP   = 2;
    localparam int DEF_NUM_RP   = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    localparam int DEF_ADDR_W = addr_w(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] data_word_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mw_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mw_if                                                        |
// | Write, read, issue and status bundle of the register file.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface regfile_mw_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addr_w(NUM_REGS),
    parameter int NUM_WP   = DEF_NUM_WP,
    parameter int NUM_RP   = DEF_NUM_RP
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_WP-1:0]        we;
    logic [NUM_WP*ADDR_W-1:0] waddr;
    logic [NUM_WP*DATA_W-1:0] wdata;
    logic [NUM_RP*ADDR_W-1:0] raddr;
    logic [NUM_RP*DATA_W-1:0] rdata;
    logic [NUM_RP-1:0]        rbusy;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_addr;
    logic [NUM_REGS-1:0]      wen;
    logic                     wconflict;
    logic [CNT_W-1:0]         busy_count;

    modport master (
        output we, waddr, wdata, raddr, issue_valid, issue_addr,
        input  rdata, rbusy, wen, wconflict, busy_count
    );

    modport slave (
        input  we, waddr, wdata, raddr, issue_valid, issue_addr,
        output rdata, rbusy, wen, wconflict, busy_count
    );

endinterface
`default_nettype wire

// File: rtl/regfile_mw_wr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wr_decoder                                                           |
// | Address to one-hot write enable, with optional register-0 mask.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wr_decoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  wire logic                i_en,
    input  wire logic [ADDR_W-1:0]   i_addr,
    output logic      [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_addr] = 1'b1;
        if (ZERO_REG != 0) o_onehot[0] = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_mw                                                           |
// | Multi-port register file with write priority, bypass and scoreboard. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_mw
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = addr_w(NUM_REGS),
    parameter int NUM_WP   = DEF_NUM_WP,
    parameter int NUM_RP   = DEF_NUM_RP,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input wire logic    clk,
    input wire logic    reset_n,
    regfile_mw_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] dec [NUM_WP];

    generate
        for (genvar p = 0; p < NUM_WP; p++) begin : g_dec
            wr_decoder #(
                .ADDR_W   (ADDR_W),
                .NUM_REGS (NUM_REGS),
                .ZERO_REG (ZERO_REG)
            ) u_dec (
                .i_en     (bus.we[p]),
                .i_addr   (bus.waddr[p*ADDR_W +: ADDR_W]),
                .o_onehot (dec[p])
            );
        end
    endgenerate

    logic [NUM_REGS-1:0] wen;
    logic [DATA_W-1:0]   win_data [NUM_REGS];
    logic                wconflict_d;

    // Ascending port scan: a later port overrides, so the highest index wins.
    always_comb begin
        wen         = '0;
        wconflict_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) win_data[r] = '0;
        for (int p = 0; p < NUM_WP; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (dec[p][r]) begin
                    if (wen[r]) wconflict_d = 1'b1;
                    wen[r]      = 1'b1;
                    win_data[r] = bus.wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    busy_count_q, busy_count_d;
    logic                wconflict_q;
    logic                issue_eff;

    assign issue_eff = bus.issue_valid && !((ZERO_REG != 0) && (bus.issue_addr == '0));

    // A fresh issue overrides a same-cycle clear: the new producer is still pending.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) regs_d[r] = wen[r] ? win_data[r] : regs_q[r];
        busy_d = busy_q & ~wen;
        if (issue_eff) busy_d[bus.issue_addr] = 1'b1;
        busy_count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) busy_count_d = busy_count_d + CNT_W'(busy_d[r]);
    end

    logic [NUM_RP*DATA_W-1:0] rdata;
    logic [NUM_RP-1:0]        rbusy;

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RP; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = bus.raddr[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (ra == '0))
                rdata[i*DATA_W +: DATA_W] = '0;
            else if ((BYPASS != 0) && wen[ra])
                rdata[i*DATA_W +: DATA_W] = win_data[ra];
            else
                rdata[i*DATA_W +: DATA_W] = regs_q[ra];
            rbusy[i] = busy_q[ra];
            if ((BYPASS != 0) && wen[ra] && !(issue_eff && (bus.issue_addr == ra)))
                rbusy[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
            wconflict_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            wconflict_q  <= wconflict_d;
        end
    end

    assign bus.rdata      = rdata;
    assign bus.rbusy      = rbusy;
    assign bus.wen        = wen;
    assign bus.wconflict  = wconflict_q;
    assign bus.busy_count = busy_count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mw.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_mw                                                        |
// | Scoreboard bench: expectations queued at drive, checked at negedge.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_mw;
    import regfile_pkg::*;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NW  = 2;
    localparam int NRP = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_mw_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_WP(NW), .NUM_RP(NRP)) bus ();

    regfile_mw #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_WP(NW), .NUM_RP(NRP),
        .ZERO_REG(1), .BYPASS(1)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef enum int {K_RDATA, K_RBUSY, K_CNT, K_WCONF, K_WEN} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mdl [NR];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_t k, input int idx);
        case (k)
            K_RDATA: return bus.rdata[idx*DW +: DW];
            K_RBUSY: return {31'b0, bus.rbusy[idx]};
            K_CNT:   return 32'(bus.busy_count);
            K_WCONF: return {31'b0, bus.wconflict};
            default: return bus.wen;
        endcase
    endfunction

    task automatic expect_val(input string tag, input kind_t k, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.idx = idx; e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk_eq(e.tag, observe(e.kind, e.idx), e.val);
        end
    endtask

    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we = '0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        bus.we[p] = 1'b1;
        bus.waddr[p*AW +: AW] = AW'(a);
        bus.wdata[p*DW +: DW] = d;
    endtask

    task automatic rd(input int i, input int a);
        bus.raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic issue(input int a);
        bus.issue_valid = 1'b1;
        bus.issue_addr  = AW'(a);
    endtask

    function automatic logic [31:0] model_read(input int a, input bit w0, input int a0, input logic [31:0] d0,
                                               input bit w1, input int a1, input logic [31:0] d1);
        if (a == 0) return 32'h0;
        if (w1 && a1 == a) return d1;
        if (w0 && a0 == a) return d0;
        return mdl[a];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, a1, r0, r1;
        bit w0, w1, prev_conf;
        logic [31:0] d0, d1;

        reset_n = 1'b0;
        idle_inputs();
        for (int r = 0; r < NR; r++) mdl[r] = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state: every register reads zero, no pending work
        for (int r = 0; r < NR; r += 2) begin
            idle_inputs();
            rd(0, r); rd(1, r + 1);
            expect_val($sformatf("rst_rd_r%0d", r), K_RDATA, 0, 32'h0);
            expect_val($sformatf("rst_rd_r%0d", r + 1), K_RDATA, 1, 32'h0);
            if (r == 0) begin
                expect_val("rst_cnt", K_CNT, 0, 32'd0);
                expect_val("rst_wconf", K_WCONF, 0, 32'd0);
                expect_val("rst_wen", K_WEN, 0, 32'd0);
            end
            step();
        end

        // Single write with bypass, then stored value
        idle_inputs(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
        expect_val("byp_r5", K_RDATA, 0, 32'hDEADBEEF);
        expect_val("wen_r5", K_WEN, 0, 32'h0000_0020);
        step();
        idle_inputs(); rd(0, 5);
        expect_val("rd_r5", K_RDATA, 0, 32'hDEADBEEF);
        expect_val("wconf_r5", K_WCONF, 0, 32'd0);
        step();

        // Register 0 writes are dropped and never conflict
        idle_inputs(); wr(0, 0, 32'h12345678); wr(1, 0, 32'h1); rd(0, 0);
        expect_val("byp_r0", K_RDATA, 0, 32'h0);
        expect_val("wen_r0", K_WEN, 0, 32'h0);
        step();
        idle_inputs(); rd(0, 0);
        expect_val("rd_r0", K_RDATA, 0, 32'h0);
        expect_val("wconf_r0", K_WCONF, 0, 32'd0);
        step();

        // Same-register conflict: port 1 wins, one-cycle pulse
        idle_inputs(); wr(0, 7, 32'h1); wr(1, 7, 32'h2); rd(0, 7);
        expect_val("byp_r7", K_RDATA, 0, 32'h2);
        expect_val("wen_r7", K_WEN, 0, 32'h0000_0080);
        step();
        idle_inputs(); rd(0, 7);
        expect_val("rd_r7", K_RDATA, 0, 32'h2);
        expect_val("wconf_pulse", K_WCONF, 0, 32'd1);
        step();
        idle_inputs();
        expect_val("wconf_drop", K_WCONF, 0, 32'd0);
        step();

        // Back-to-back conflicts hold the flag high
        idle_inputs(); wr(0, 10, 32'hA0); wr(1, 10, 32'hA1);
        step();
        idle_inputs(); wr(0, 11, 32'hB0); wr(1, 11, 32'hB1);
        expect_val("wconf_b2b_1", K_WCONF, 0, 32'd1);
        step();
        idle_inputs(); rd(0, 10); rd(1, 11);
        expect_val("wconf_b2b_2", K_WCONF, 0, 32'd1);
        expect_val("rd_r10", K_RDATA, 0, 32'hA1);
        expect_val("rd_r11", K_RDATA, 1, 32'hB1);
        step();
        idle_inputs();
        expect_val("wconf_b2b_end", K_WCONF, 0, 32'd0);
        step();

        // Scoreboard: issue, write+reissue keeps busy, plain write clears
        idle_inputs(); issue(9); rd(0, 9);
        expect_val("sb_issue_rbusy", K_RBUSY, 0, 32'd0);
        expect_val("sb_issue_cnt", K_CNT, 0, 32'd0);
        step();
        idle_inputs(); rd(0, 9);
        expect_val("sb_set_rbusy", K_RBUSY, 0, 32'd1);
        expect_val("sb_set_cnt", K_CNT, 0, 32'd1);
        step();
        idle_inputs(); wr(0, 9, 32'hAA); issue(9); rd(0, 9);
        expect_val("sb_reissue_rbusy", K_RBUSY, 0, 32'd1);
        expect_val("sb_reissue_rdata", K_RDATA, 0, 32'hAA);
        step();
        idle_inputs(); rd(0, 9);
        expect_val("sb_still_rbusy", K_RBUSY, 0, 32'd1);
        expect_val("sb_still_cnt", K_CNT, 0, 32'd1);
        step();
        idle_inputs(); wr(1, 9, 32'hBB); rd(0, 9);
        expect_val("sb_clr_byp_rbusy", K_RBUSY, 0, 32'd0);
        expect_val("sb_clr_old_cnt", K_CNT, 0, 32'd1);
        step();
        idle_inputs(); rd(0, 9);
        expect_val("sb_clr_rbusy", K_RBUSY, 0, 32'd0);
        expect_val("sb_clr_cnt", K_CNT, 0, 32'd0);
        expect_val("sb_clr_rdata", K_RDATA, 0, 32'hBB);
        step();

        // Issue to register 0 is ignored
        idle_inputs(); issue(0);
        step();
        idle_inputs(); rd(0, 0);
        expect_val("sb_r0_rbusy", K_RBUSY, 0, 32'd0);
        expect_val("sb_r0_cnt", K_CNT, 0, 32'd0);
        step();

        // Several pending registers, then asynchronous reset between edges
        idle_inputs(); issue(3); step();
        idle_inputs(); issue(4);
        expect_val("multi_cnt1", K_CNT, 0, 32'd1);
        step();
        idle_inputs(); issue(6);
        expect_val("multi_cnt2", K_CNT, 0, 32'd2);
        step();
        idle_inputs(); rd(0, 3); rd(1, 6);
        expect_val("multi_cnt3", K_CNT, 0, 32'd3);
        expect_val("multi_rbusy3", K_RBUSY, 0, 32'd1);
        expect_val("multi_rbusy6", K_RBUSY, 1, 32'd1);
        step();
        idle_inputs(); issue(8); rd(0, 4); rd(1, 5);
        reset_n = 1'b0;
        #1;
        expect_val("arst_cnt", K_CNT, 0, 32'd0);
        expect_val("arst_rbusy4", K_RBUSY, 0, 32'd0);
        expect_val("arst_rbusy5", K_RBUSY, 1, 32'd0);
        expect_val("arst_rdata5", K_RDATA, 1, 32'h0);
        expect_val("arst_wconf", K_WCONF, 0, 32'd0);
        drain();
        idle_inputs();
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int r = 0; r < NR; r++) mdl[r] = '0;
        idle_inputs(); rd(0, 8);
        expect_val("post_rst_rbusy8", K_RBUSY, 0, 32'd0);
        expect_val("post_rst_cnt", K_CNT, 0, 32'd0);
        step();

        // Random writes against the reference model
        prev_conf = 1'b0;
        for (int it = 0; it < 24; it++) begin
            idle_inputs();
            a0 = $urandom_range(0, NR - 1);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, NR - 1);
            d0 = $urandom; d1 = $urandom;
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            r0 = ($urandom_range(0, 1) == 0) ? a0 : $urandom_range(0, NR - 1);
            r1 = ($urandom_range(0, 1) == 0) ? a1 : $urandom_range(0, NR - 1);
            if (w0) wr(0, a0, d0);
            if (w1) wr(1, a1, d1);
            rd(0, r0); rd(1, r1);
            expect_val($sformatf("rnd%0d_rd0", it), K_RDATA, 0, model_read(r0, w0, a0, d0, w1, a1, d1));
            expect_val($sformatf("rnd%0d_rd1", it), K_RDATA, 1, model_read(r1, w0, a0, d0, w1, a1, d1));
            expect_val($sformatf("rnd%0d_wconf", it), K_WCONF, 0, {31'b0, prev_conf});
            step();
            if (w0 && a0 != 0) mdl[a0] = d0;
            if (w1 && a1 != 0) mdl[a1] = d1;
            prev_conf = w0 && w1 && (a0 == a1) && (a0 != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
